// File: rtl/camera_trigger_sequencer_if.sv
// rtl/camera_trigger_sequencer_if.sv - Avalon-MM register bus bundle for the camera trigger sequencer
interface camera_trigger_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/camera_trigger_sequencer.sv
// rtl/camera_trigger_sequencer.sv - Avalon-MM camera trigger and frame burst sequencer
module camera_trigger_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  camera_trigger_sequencer_if.slave avs,
  input  logic                      cam_framevalid,
  input  logic                      cam_linevalid,
  output logic                      cam_trigger,
  output logic                      busy,
  output logic                      irq
);
  // Last value of the timeout counter before the burst is abandoned.
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYC > 1) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_FV,
    S_FRAME,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Software-visible configuration and the copies used by a running burst.
  logic [15:0] num_frames, trig_width;
  logic [31:0] gap;
  logic [15:0] sh_num, sh_width;
  logic [31:0] sh_gap;

  logic [15:0] width_cnt;
  logic [31:0] timeout_cnt, gap_cnt;
  logic [15:0] frames_done, lines_cnt, lines_last;
  logic        done, error;
  logic        fv_d, lv_d;

  logic        wr_ctrl, start_req, abort_req, clear_req;
  logic        fv_rise, fv_fall, lv_rise;
  logic [15:0] frames_inc;
  logic        do_start, frame_end, set_done, set_error;
  logic        enter_trig, enter_wait, enter_gap;

  assign wr_ctrl    = avs.avs_write && (avs.avs_address == 2'd0);
  assign abort_req  = wr_ctrl && avs.avs_writedata[1];
  assign start_req  = wr_ctrl && avs.avs_writedata[0] && !avs.avs_writedata[1];
  assign clear_req  = wr_ctrl && avs.avs_writedata[3];

  assign fv_rise    = cam_framevalid & ~fv_d;
  assign fv_fall    = ~cam_framevalid & fv_d;
  assign lv_rise    = cam_linevalid & ~lv_d;
  assign frames_inc = frames_done + 16'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state selection, status set events and the pin-level outputs.
  always_comb begin
    state_nxt   = state;
    do_start    = 1'b0;
    frame_end   = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;
    cam_trigger = (state == S_TRIG);
    busy        = (state != S_IDLE);
    irq         = done | error;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          do_start  = 1'b1;
          state_nxt = S_TRIG;
        end
      end
      S_TRIG: begin
        if (width_cnt == sh_width) state_nxt = S_WAIT_FV;
      end
      S_WAIT_FV: begin
        if (fv_rise) begin
          state_nxt = S_FRAME;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          set_error = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FRAME: begin
        if (fv_fall) begin
          frame_end = 1'b1;
          if (frames_inc == sh_num)  state_nxt = S_DONE;
          else if (sh_gap == 32'd0)  state_nxt = S_TRIG;
          else                       state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == sh_gap) state_nxt = S_TRIG;
      end
      S_DONE: begin
        set_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort leaves every flag and count untouched and simply returns to idle.
    if (abort_req && state != S_IDLE) begin
      state_nxt = S_IDLE;
      frame_end = 1'b0;
      set_done  = 1'b0;
      set_error = 1'b0;
    end
  end

  assign enter_trig = (state_nxt == S_TRIG)    && (state != S_TRIG);
  assign enter_wait = (state_nxt == S_WAIT_FV) && (state != S_WAIT_FV);
  assign enter_gap  = (state_nxt == S_GAP)     && (state != S_GAP);

  // Delayed copies of the camera strobes for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fv_d <= 1'b0;
      lv_d <= 1'b0;
    end else begin
      fv_d <= cam_framevalid;
      lv_d <= cam_linevalid;
    end
  end

  // Readable configuration registers; writable at any time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_frames <= 16'd0;
      trig_width <= 16'd0;
      gap        <= 32'd0;
    end else if (avs.avs_write) begin
      case (avs.avs_address)
        2'd1:    num_frames <= avs.avs_writedata[15:0];
        2'd2:    trig_width <= avs.avs_writedata[15:0];
        2'd3:    gap        <= avs.avs_writedata;
        default: ;
      endcase
    end
  end

  // Burst shadows (zero counts promoted to one) and the width/timeout/gap timers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_num      <= 16'd0;
      sh_width    <= 16'd0;
      sh_gap      <= 32'd0;
      width_cnt   <= 16'd0;
      timeout_cnt <= 32'd0;
      gap_cnt     <= 32'd0;
    end else begin
      if (do_start) begin
        sh_num   <= (num_frames == 16'd0) ? 16'd1 : num_frames;
        sh_width <= (trig_width == 16'd0) ? 16'd1 : trig_width;
        sh_gap   <= gap;
      end
      if (enter_trig)             width_cnt <= 16'd1;
      else if (state == S_TRIG)   width_cnt <= width_cnt + 16'd1;
      if (enter_wait)             timeout_cnt <= 32'd0;
      else if (state == S_WAIT_FV) timeout_cnt <= timeout_cnt + 32'd1;
      if (enter_gap)              gap_cnt <= 32'd1;
      else if (state == S_GAP)    gap_cnt <= gap_cnt + 32'd1;
    end
  end

  // Frame/line bookkeeping and sticky completion flags; a hardware set beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frames_done <= 16'd0;
      lines_cnt   <= 16'd0;
      lines_last  <= 16'd0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (do_start) begin
        frames_done <= 16'd0;
        done        <= 1'b0;
        error       <= 1'b0;
      end else begin
        if (frame_end) begin
          frames_done <= frames_inc;
          lines_last  <= lines_cnt;
        end
        if (set_done)       done <= 1'b1;
        else if (clear_req) done <= 1'b0;
        if (set_error)      error <= 1'b1;
        else if (clear_req) error <= 1'b0;
      end
      if (state == S_WAIT_FV && fv_rise)
        lines_cnt <= 16'd0;
      else if (state == S_FRAME && lv_rise && cam_framevalid && lines_cnt != 16'hFFFF)
        lines_cnt <= lines_cnt + 16'd1;
    end
  end

  // Registered read data, presented the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avs.avs_readdata <= 32'd0;
    end else if (avs.avs_read) begin
      case (avs.avs_address)
        2'd0:    avs.avs_readdata <= {frames_done, 13'd0, error, done, busy};
        2'd1:    avs.avs_readdata <= {lines_last, num_frames};
        2'd2:    avs.avs_readdata <= {16'd0, trig_width};
        default: avs.avs_readdata <= gap;
      endcase
    end
  end
endmodule

// File: tb/tb_camera_trigger_sequencer.sv
// tb/tb_camera_trigger_sequencer.sv - randomized self-checking bench for camera_trigger_sequencer
module tb_camera_trigger_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cam_framevalid = 1'b0;
  logic cam_linevalid = 1'b0;
  logic cam_trigger, busy, irq;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ref_cyc = 0;

  camera_trigger_sequencer_if bus ();

  camera_trigger_sequencer #(.TIMEOUT_CYC(50)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs            (bus),
    .cam_framevalid (cam_framevalid),
    .cam_linevalid  (cam_linevalid),
    .cam_trigger    (cam_trigger),
    .busy           (busy),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One bench cycle: outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic av_write(input logic [1:0] addr, input logic [31:0] data);
    step();
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    ref_cyc           = cyc;
    step();
    bus.avs_write     = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] addr, output logic [31:0] data);
    step();
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    step();
    bus.avs_read    = 1'b0;
    data            = bus.avs_readdata;
  endtask

  // Reference behaviour: trigger appears 1 cycle after start or 1+GAP after a
  // framevalid fall, lasts max(TRIG_WIDTH,1) cycles, burst length max(NUM,1).
  task automatic run_burst(input int num, input int tw, input int gp, input bit mid_write);
    int eff_num, eff_tw, n, lines, last_lines, new_num;
    logic [31:0] rd;
    eff_num    = (num == 0) ? 1 : num;
    eff_tw     = (tw == 0) ? 1 : tw;
    new_num    = num;
    last_lines = 0;
    av_write(2'd1, 32'(num));
    av_write(2'd2, 32'(tw));
    av_write(2'd3, 32'(gp));
    av_write(2'd0, 32'h1);
    for (int f = 0; f < eff_num; f++) begin
      n = 0;
      while (!cam_trigger && n < gp + 20) begin step(); n++; end
      check_eq("trig_start", 32'(cyc - ref_cyc), 32'(1 + ((f == 0) ? 0 : gp)));
      if (f == 0) check_eq("irq_clr_on_start", {31'd0, irq}, 32'd0);
      n = 0;
      while (cam_trigger && n < 100) begin step(); n++; end
      check_eq("trig_width", 32'(n), 32'(eff_tw));
      repeat ($urandom_range(1, 6)) step();
      cam_framevalid = 1'b1;
      step();
      if (mid_write && f == 0) begin
        av_write(2'd0, 32'h1);
        new_num = int'($urandom_range(1, 9));
        av_write(2'd1, 32'(new_num));
      end
      lines = int'($urandom_range(0, 4));
      for (int l = 0; l < lines; l++) begin
        cam_linevalid = 1'b1; step(); step();
        cam_linevalid = 1'b0; step(); step();
      end
      step();
      cam_framevalid = 1'b0;
      ref_cyc        = cyc;
      last_lines     = lines;
      step();
      if (f == eff_num - 1) begin
        check_eq("busy_in_done", {31'd0, busy}, 32'd1);
        check_eq("irq_before_done", {31'd0, irq}, 32'd0);
        step();
        check_eq("irq_done", {31'd0, irq}, 32'd1);
        check_eq("busy_after_done", {31'd0, busy}, 32'd0);
      end
    end
    av_read(2'd0, rd);
    check_eq("status", rd, {16'(eff_num), 16'h0002});
    av_read(2'd1, rd);
    check_eq("lines_num", rd, {16'(last_lines), 16'(new_num)});
    av_read(2'd2, rd);
    check_eq("trig_width_rb", rd, 32'(tw));
    av_read(2'd3, rd);
    check_eq("gap_rb", rd, 32'(gp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    bus.avs_address   = 2'd0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;
    bus.avs_read      = 1'b0;
    repeat (3) step();
    check_eq("rst_trig", {31'd0, cam_trigger}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_rdata", bus.avs_readdata, 32'd0);
    reset_n = 1'b1;
    step();
    av_read(2'd0, rd);
    check_eq("rst_status", rd, 32'd0);

    // Directed bursts: single frame, gapped burst, mid-burst writes, zero values.
    run_burst(1, 4, 0, 1'b0);
    run_burst(3, 2, 10, 1'b0);
    run_burst(2, 3, 3, 1'b1);
    run_burst(0, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));

    // Timeout: no framevalid after the trigger.
    av_write(2'd2, 32'd3);
    av_write(2'd0, 32'h1);
    n = 0;
    while (cam_trigger && n < 100) begin step(); n++; end
    check_eq("to_trig_width", 32'(n), 32'd3);
    n = 0;
    while (!irq && n < 200) begin step(); n++; end
    check_eq("to_latency", 32'(n), 32'd50);
    check_eq("to_busy", {31'd0, busy}, 32'd0);
    av_read(2'd0, rd);
    check_eq("to_status", rd, 32'h0000_0004);
    av_write(2'd0, 32'h8);
    check_eq("to_clear_irq", {31'd0, irq}, 32'd0);

    // Abort while a frame is in progress, then start+abort together.
    av_write(2'd1, 32'd2);
    av_write(2'd2, 32'd2);
    av_write(2'd3, 32'd0);
    av_write(2'd0, 32'h1);
    n = 0;
    while (cam_trigger && n < 100) begin step(); n++; end
    step();
    cam_framevalid = 1'b1;
    step(); step();
    av_write(2'd0, 32'h2);
    check_eq("ab_trig", {31'd0, cam_trigger}, 32'd0);
    check_eq("ab_busy", {31'd0, busy}, 32'd0);
    check_eq("ab_irq", {31'd0, irq}, 32'd0);
    cam_framevalid = 1'b0;
    step(); step();
    check_eq("ab_idle_fall", {31'd0, busy}, 32'd0);
    av_read(2'd0, rd);
    check_eq("ab_status", rd, 32'd0);
    av_write(2'd0, 32'h3);
    check_eq("sa_busy", {31'd0, busy}, 32'd0);
    check_eq("sa_trig", {31'd0, cam_trigger}, 32'd0);
    step(); step();
    check_eq("sa_busy_later", {31'd0, busy}, 32'd0);

    // Reset in the middle of a trigger pulse, then a fresh burst.
    av_write(2'd2, 32'd6);
    av_read(2'd2, rd);
    av_write(2'd0, 32'h1);
    step();
    check_eq("mr_trig_before", {31'd0, cam_trigger}, 32'd1);
    reset_n = 1'b0;
    step();
    check_eq("mr_trig", {31'd0, cam_trigger}, 32'd0);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    check_eq("mr_irq", {31'd0, irq}, 32'd0);
    check_eq("mr_rdata", bus.avs_readdata, 32'd0);
    reset_n = 1'b1;
    step();
    run_burst(2, 2, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
